cache_controller_assoc: RTL and testbench
=========================================

Name: cache_controller_assoc

Overview:
- Parametrised N-way set-associative successor to the direct-mapped data-cache controller; sits between the RISC-V datapath and the cache data array / main-memory model.
- Holds tag and valid state per way, computes hit and hit way, and drives the stall / refill / update / memory-read / memory-write strobes.
- Adds three behaviours: round-robin victim selection with invalid-way priority, a whole-cache flush sequence, and write-hit way reporting.
- Policy is write-through, no-write-allocate.

Parameters:
- TAG_W, 3, tag width in bits.
- INDEX_W, 5, set-index width; number of sets is 2^INDEX_W.
- WAYS, 2, associativity; legal values are 1, 2 and 4.
- WAY_W is derived as clog2(WAYS), forced to 1 when WAYS=1; it is not overridable.

Ports:
- clk  in  1  clock; all state updates on the falling edge, matching the processor's cache integration.
- rst  in  1  asynchronous, active-low reset.
- mem_read  in  1  load request from datapath.
- mem_write  in  1  store request from datapath.
- ready  in  1  main memory completed the current read or write.
- flush  in  1  request to invalidate the entire cache; sampled only in IDLE.
- tag  in  TAG_W  address tag.
- index  in  INDEX_W  set index.
- stall  out  1  freeze the pipeline.
- cache_read  out  1  read hit; the data array drives data from hit_way.
- hit  out  1  combinational lookup result.
- hit_way  out  WAY_W  matching way; lowest index wins; 0 when there is no hit.
- refill  out  1  write memory data into the data array at refill_way.
- refill_way  out  WAY_W  victim way latched for the current miss.
- update  out  1  write-hit; the data array writes store data at update_way.
- update_way  out  WAY_W  way latched for the current write hit.
- read  out  1  main-memory read request.
- write  out  1  main-memory write request.
- flush_busy  out  1  flush sequence in progress.

Behaviour:
- Reset (rst=0, asynchronous): state goes to IDLE; all valid bits, tags, round-robin pointers and the flush counter clear to 0; every registered output and latched way is 0.
- Reset asserted mid-miss, mid-write or mid-flush abandons the operation with no partial tag write.
- Lookup (combinational): hit = OR over ways of (valid[w][index] && tag_mem[w][index]==tag).
- Victim selection: the lowest invalid way of the set; if all ways are valid, use rr_ptr[index].
- IDLE: stall=0.
  - cache_read = hit && mem_read, zero latency.
- IDLE transitions, in priority order:
  - flush goes to FLUSH.
  - mem_read && !hit goes to RD_MISS; latches refill_way = victim.
  - mem_write goes to WR_MEM; latches hit to wr_hit and hit_way to update_way.
  - mem_read && mem_write together is a protocol violation; read priority applies.
- RD_MISS: stall=1, read=1, refill=1.
  - On the falling edge with ready=1: valid[refill_way][index] goes to 1 and tag_mem[refill_way][index] goes to tag.
  - On that same edge, rr_ptr[index] goes to (refill_way+1) mod WAYS.
  - Next state is IDLE.
  - Tag and valid are never written outside RD_MISS.
- WR_MEM: stall=1, write=1, update=wr_hit.
  - Tags and valid bits are unchanged (no allocate).
  - ready=1 goes to IDLE.
- ready=0 holds RD_MISS and WR_MEM indefinitely; there is no timeout.
- FLUSH: stall=1, flush_busy=1.
  - Each falling edge clears valid of all ways for set fcnt, then increments fcnt.
  - After clearing set 2^INDEX_W-1, fcnt wraps to 0 and the state goes to IDLE.
  - Flush lasts exactly 2^INDEX_W cycles; tags are not cleared.
  - mem_read, mem_write and ready are ignored during FLUSH.
- Flush asserted while in RD_MISS or WR_MEM is ignored; the requester holds it until flush_busy rises.
- A read hit on a set mid-refill cannot occur, because the pipeline is stalled.
- WAYS=1 degenerates to direct-mapped: hit_way, refill_way and update_way are all 0, and rr_ptr is unused.
- The state encoding is 2 bits: IDLE=00, RD_MISS=01, WR_MEM=11, FLUSH=10.

Decomposition:
- Package cache_pkg holds:
  - the state localparams;
  - the legal-WAYS check;
  - the clog2-based WAY_W function shared with the data-array block.
- Sub-module cache_tag_array is natural. It holds per-way valid and tag storage plus rr_ptr, with:
  - a parallel compare and a priority encoder producing hit and hit_way;
  - victim selection;
  - a refill write port and a per-set clear port.
- The controller FSM and flush counter stay in the top module.

Test Plan:
- Reset then cold read tag=3'h5, index=5'd7 → RD_MISS, stall=read=refill=1, refill_way=0. ready pulsed after 3 cycles → IDLE. Repeat read gives hit=1, cache_read=1, hit_way=0, stall=0.
- Same index, read tag=3'h2 → miss, refill_way=1 (invalid-first). A third tag=3'h6 → refill_way=0 (rr_ptr). A following read of tag=3'h5 misses; tag=3'h2 still hits on way 1.
- Write hit tag=3'h2, index=5'd7 → WR_MEM, write=1, update=1, update_way=1 until ready. Write miss tag=3'h1 → update=0, and a subsequent read of tag=3'h1 misses (no allocate).
- Fill sets 0, 15 and 31, then assert flush → flush_busy=1 and stall=1 for exactly 32 cycles; afterwards reads of all three sets miss. A mem_read during the flush produces no read strobe.
- Drive rst=0 asynchronously mid-RD_MISS, between clock edges → outputs 0 immediately. After release, the previously hitting line misses and the set being refilled holds no valid entry.
- WAYS=4, INDEX_W=2 build: five distinct tags to one set → refill_way sequence 0,1,2,3,0. hit_way is correct for each resident tag.

Source files
------------

// File: rtl/cache_controller_assoc_pkg.sv
// Shared definitions for the set-associative cache controller.
//   state_t    : 2-bit controller state encoding (IDLE/RD_MISS/WR_MEM/FLUSH)
//   ways_legal : true for the supported associativities (1, 2, 4)
//   way_w_f    : way-number width, clog2(WAYS) with a floor of 1 bit;
//                also used by the data-array block so both agree on width
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RD_MISS = 2'b01,
    ST_WR_MEM  = 2'b11,
    ST_FLUSH   = 2'b10
  } state_t;

  function automatic bit ways_legal(input int ways);
    return (ways == 1) || (ways == 2) || (ways == 4);
  endfunction

  function automatic int way_w_f(input int ways);
    return (ways <= 1) ? 1 : $clog2(ways);
  endfunction

endpackage

// File: rtl/cache_controller_assoc_tag_array.sv
// Per-way tag/valid storage plus per-set round-robin pointer.
//   i_tag/i_index       : lookup address (also the refill write address)
//   o_hit/o_hit_way     : parallel compare, lowest matching way wins
//   o_victim            : lowest invalid way, else rr_ptr[index]
//   i_refill_we/_way    : write tag, set valid, advance rr_ptr for i_index
//   i_clr_we/i_clr_index: clear every valid bit of one set (tags kept)
// State updates on the falling clock edge; rst is asynchronous active-low.
module cache_tag_array
  import cache_pkg::*;
#(
  parameter int TAG_W   = 3,
  parameter int INDEX_W = 5,
  parameter int WAYS    = 2,
  parameter int WAY_W   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TAG_W-1:0]   i_tag,
  input  logic [INDEX_W-1:0] i_index,
  output logic               o_hit,
  output logic [WAY_W-1:0]   o_hit_way,
  output logic [WAY_W-1:0]   o_victim,
  input  logic               i_refill_we,
  input  logic [WAY_W-1:0]   i_refill_way,
  input  logic               i_clr_we,
  input  logic [INDEX_W-1:0] i_clr_index
);

  localparam int SETS = 1 << INDEX_W;

  logic [WAYS-1:0]  r_valid [SETS];
  logic [TAG_W-1:0] r_tag   [WAYS][SETS];
  logic [WAY_W-1:0] r_rr    [SETS];

  logic [WAYS-1:0]  w_match;
  logic [WAYS-1:0]  w_valid_set;
  logic [WAY_W-1:0] w_rr_next;

  assign w_valid_set = r_valid[i_index];

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_cmp
      assign w_match[gi] = w_valid_set[gi] && (r_tag[gi][i_index] == i_tag);
    end
  endgenerate

  assign o_hit = |w_match;

  // Scan downwards so the lowest-numbered candidate is the one left standing.
  always_comb begin
    logic w_any_invalid;
    o_hit_way     = '0;
    o_victim      = '0;
    w_any_invalid = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (w_match[i]) o_hit_way = WAY_W'(i);
      if (!w_valid_set[i]) begin
        o_victim      = WAY_W'(i);
        w_any_invalid = 1'b1;
      end
    end
    if (!w_any_invalid) o_victim = r_rr[i_index];
  end

  // Explicit wrap keeps non-power-of-two-sized way fields (WAYS=1) at zero.
  assign w_rr_next = (i_refill_way == WAY_W'(WAYS - 1)) ? '0 : i_refill_way + 1'b1;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
        for (int w = 0; w < WAYS; w++) r_tag[w][s] <= '0;
      end
    end else begin
      if (i_clr_we) r_valid[i_clr_index] <= '0;
      if (i_refill_we) begin
        r_valid[i_index][i_refill_way] <= 1'b1;
        r_tag[i_refill_way][i_index]   <= i_tag;
        r_rr[i_index]                  <= w_rr_next;
      end
    end
  end

endmodule

// File: rtl/cache_controller_assoc.sv
// N-way set-associative, write-through / no-write-allocate cache controller.
// Inputs : clk (falling-edge active), rst (async, active-low), mem_read,
//          mem_write, ready, flush, tag, index.
// Outputs: stall, cache_read, hit, hit_way, refill, refill_way, update,
//          update_way, read, write, flush_busy.
// Read misses refill a victim way; writes go to memory and update the data
// array only on a hit; flush walks every set clearing valid bits.
module cache_controller_assoc
  import cache_pkg::*;
#(
  parameter  int TAG_W   = 3,
  parameter  int INDEX_W = 5,
  parameter  int WAYS    = 2,
  localparam int WAY_W   = way_w_f(WAYS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic               ready,
  input  logic               flush,
  input  logic [TAG_W-1:0]   tag,
  input  logic [INDEX_W-1:0] index,
  output logic               stall,
  output logic               cache_read,
  output logic               hit,
  output logic [WAY_W-1:0]   hit_way,
  output logic               refill,
  output logic [WAY_W-1:0]   refill_way,
  output logic               update,
  output logic [WAY_W-1:0]   update_way,
  output logic               read,
  output logic               write,
  output logic               flush_busy
);

  generate
    if (!ways_legal(WAYS)) begin : g_ways_illegal
      $error("cache_controller_assoc: WAYS must be 1, 2 or 4");
    end
  endgenerate

  state_t             r_state, w_state_next;
  logic [INDEX_W-1:0] r_fcnt;
  logic [WAY_W-1:0]   r_refill_way, r_update_way;
  logic               r_wr_hit;
  logic               w_hit;
  logic [WAY_W-1:0]   w_hit_way, w_victim;

  cache_tag_array #(
    .TAG_W  (TAG_W),
    .INDEX_W(INDEX_W),
    .WAYS   (WAYS),
    .WAY_W  (WAY_W)
  ) u_tags (
    .clk         (clk),
    .rst         (rst),
    .i_tag       (tag),
    .i_index     (index),
    .o_hit       (w_hit),
    .o_hit_way   (w_hit_way),
    .o_victim    (w_victim),
    .i_refill_we (r_state == ST_RD_MISS && ready),
    .i_refill_way(r_refill_way),
    .i_clr_we    (r_state == ST_FLUSH),
    .i_clr_index (r_fcnt)
  );

  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    cache_read   = 1'b0;
    refill       = 1'b0;
    update       = 1'b0;
    read         = 1'b0;
    write        = 1'b0;
    flush_busy   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cache_read = w_hit && mem_read;
        // A simultaneous read and write is treated as a read.
        if (flush)                      w_state_next = ST_FLUSH;
        else if (mem_read && !w_hit)    w_state_next = ST_RD_MISS;
        else if (mem_write && !mem_read) w_state_next = ST_WR_MEM;
      end
      ST_RD_MISS: begin
        stall  = 1'b1;
        read   = 1'b1;
        refill = 1'b1;
        if (ready) w_state_next = ST_IDLE;
      end
      ST_WR_MEM: begin
        stall  = 1'b1;
        write  = 1'b1;
        update = r_wr_hit;
        if (ready) w_state_next = ST_IDLE;
      end
      ST_FLUSH: begin
        stall      = 1'b1;
        flush_busy = 1'b1;
        if (r_fcnt == '1) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_fcnt       <= '0;
      r_refill_way <= '0;
      r_update_way <= '0;
      r_wr_hit     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && w_state_next == ST_RD_MISS) r_refill_way <= w_victim;
      if (r_state == ST_IDLE && w_state_next == ST_WR_MEM) begin
        r_wr_hit     <= w_hit;
        r_update_way <= w_hit_way;
      end
      // Counter wraps to 0 on its own as the last set is cleared.
      if (r_state == ST_FLUSH) r_fcnt <= r_fcnt + 1'b1;
    end
  end

  assign hit        = w_hit;
  assign hit_way    = w_hit_way;
  assign refill_way = r_refill_way;
  assign update_way = r_update_way;

endmodule

// File: tb/tb_cache_controller_assoc.sv
module tb_cache_controller_assoc;

  // Kinds of DUT response seen by the monitors
  localparam int K_RHIT = 0, K_RMISS = 1, K_WR = 2, K_FSTART = 3, K_FEND = 4;

  typedef struct {
    int    kind;
    int    way;
    int    upd;
    int    len;
    string name;
  } resp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 2-way, 32-set instance
  logic       mem_read, mem_write, ready, flush;
  logic [2:0] tag;
  logic [4:0] index;
  logic       stall, cache_read, hit, refill, update, read, write, flush_busy;
  logic [0:0] hit_way, refill_way, update_way;

  // 4-way, 4-set instance
  logic       m4_read, m4_write, m4_ready, m4_flush;
  logic [2:0] m4_tag;
  logic [1:0] m4_index;
  logic       s4_stall, s4_cache_read, s4_hit, s4_refill, s4_update, s4_read, s4_write, s4_flush_busy;
  logic [1:0] s4_hit_way, s4_refill_way, s4_update_way;

  cache_controller_assoc #(.TAG_W(3), .INDEX_W(5), .WAYS(2)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .ready(ready),
    .flush(flush), .tag(tag), .index(index), .stall(stall), .cache_read(cache_read),
    .hit(hit), .hit_way(hit_way), .refill(refill), .refill_way(refill_way),
    .update(update), .update_way(update_way), .read(read), .write(write),
    .flush_busy(flush_busy)
  );

  cache_controller_assoc #(.TAG_W(3), .INDEX_W(2), .WAYS(4)) dut4 (
    .clk(clk), .rst(rst), .mem_read(m4_read), .mem_write(m4_write), .ready(m4_ready),
    .flush(m4_flush), .tag(m4_tag), .index(m4_index), .stall(s4_stall),
    .cache_read(s4_cache_read), .hit(s4_hit), .hit_way(s4_hit_way), .refill(s4_refill),
    .refill_way(s4_refill_way), .update(s4_update), .update_way(s4_update_way),
    .read(s4_read), .write(s4_write), .flush_busy(s4_flush_busy)
  );

  int    n_pass = 0, n_total = 0;
  resp_t exp_q[$];
  resp_t exp4_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic match(input int q, input int kind, input int way, input int upd, input int len);
    resp_t e;
    if ((q == 0 && exp_q.size() == 0) || (q == 1 && exp4_q.size() == 0)) begin
      n_total++;
      $display("FAIL unexpected_response[%0d]: got kind %0d way %0d, expected none", q, kind, way);
      return;
    end
    if (q == 0) e = exp_q.pop_front();
    else        e = exp4_q.pop_front();
    $display("resp %-14s kind=%0d way=%0d upd=%0d len=%0d", e.name, kind, way, upd, len);
    check({e.name, "_kind"}, kind, e.kind);
    check({e.name, "_way"}, way, e.way);
    if (e.kind == K_WR) check({e.name, "_update"}, upd, e.upd);
    if (e.kind == K_FEND) begin
      check({e.name, "_len"}, len, e.len);
      check({e.name, "_rd_strobes"}, upd, e.upd);
    end
  endtask

  // Monitor, 2-way DUT: samples on the rising edge, away from state updates.
  logic prev_stall = 1'b0, prev_fb = 1'b0;
  int   fl_len = 0, fl_rd = 0;
  int   r_kind;
  always @(posedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
      prev_fb    = 1'b0;
    end else begin
      if (flush_busy && !prev_fb) begin fl_len = 0; fl_rd = 0; end
      if (flush_busy) begin fl_len++; fl_rd += int'(read); end
      if (cache_read) match(0, K_RHIT, int'(hit_way), 0, 0);
      if (stall && !prev_stall) begin
        r_kind = flush_busy ? K_FSTART : (read && refill) ? K_RMISS : write ? K_WR : 9;
        match(0, r_kind, flush_busy ? 0 : read ? int'(refill_way) : int'(update_way),
              int'(update), 0);
      end
      if (prev_fb && !flush_busy) match(0, K_FEND, 0, fl_rd, fl_len);
      prev_stall = stall;
      prev_fb    = flush_busy;
    end
  end

  // Monitor, 4-way DUT: only reads are exercised there.
  logic prev_stall4 = 1'b0;
  always @(posedge clk) begin
    if (!rst) prev_stall4 = 1'b0;
    else begin
      if (s4_cache_read) match(1, K_RHIT, int'(s4_hit_way), 0, 0);
      if (s4_stall && !prev_stall4)
        match(1, (s4_read && s4_refill) ? K_RMISS : 9, int'(s4_refill_way), 0, 0);
      prev_stall4 = s4_stall;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] t, input logic [4:0] i, input bit miss, input int way, input string nm);
    tag   = t;
    index = i;
    exp_q.push_back('{miss ? K_RMISS : K_RHIT, way, 0, 0, nm});
    mem_read = 1'b1;
    step();
    mem_read = 1'b0;
    if (miss) begin
      repeat (3) step();
      ready = 1'b1;
      step();
      ready = 1'b0;
    end
  endtask

  task automatic wr(input logic [2:0] t, input logic [4:0] i, input int way, input int upd, input string nm);
    tag   = t;
    index = i;
    exp_q.push_back('{K_WR, way, upd, 0, nm});
    mem_write = 1'b1;
    step();
    mem_write = 1'b0;
    repeat (2) step();
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  task automatic rd4(input logic [2:0] t, input logic [1:0] i, input bit miss, input int way, input string nm);
    m4_tag   = t;
    m4_index = i;
    exp4_q.push_back('{miss ? K_RMISS : K_RHIT, way, 0, 0, nm});
    m4_read = 1'b1;
    step();
    m4_read = 1'b0;
    if (miss) begin
      repeat (2) step();
      m4_ready = 1'b1;
      step();
      m4_ready = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0;
    mem_read = 0; mem_write = 0; ready = 0; flush = 0; tag = '0; index = '0;
    m4_read = 0; m4_write = 0; m4_ready = 0; m4_flush = 0; m4_tag = '0; m4_index = '0;
    repeat (2) step();
    check("reset_stall", int'(stall), 0);
    check("reset_strobes", int'({read, write, refill, update, flush_busy}), 0);
    check("reset_hit", int'({hit, cache_read}), 0);
    check("reset_ways", int'({refill_way, update_way}), 0);
    rst = 1'b1;
    step();

    // Allocation, invalid-first then round-robin, in set 7
    rd(3'h5, 5'd7, 1, 0, "cold_rd5");
    rd(3'h5, 5'd7, 0, 0, "hit_rd5");
    rd(3'h2, 5'd7, 1, 1, "miss_rd2");
    rd(3'h6, 5'd7, 1, 0, "miss_rd6_rr");
    rd(3'h2, 5'd7, 0, 1, "hit_rd2");
    // Write hit and write miss (no allocate)
    wr(3'h2, 5'd7, 1, 1, "wr_hit2");
    wr(3'h1, 5'd7, 0, 0, "wr_miss1");
    rd(3'h1, 5'd7, 1, 1, "rd1_noalloc");
    rd(3'h5, 5'd7, 1, 0, "rd5_evicted");
    rd(3'h1, 5'd7, 0, 1, "hit_rd1");

    // Flush with sets 0, 15, 31 resident
    rd(3'h3, 5'd0, 1, 0, "fill_s0");
    rd(3'h4, 5'd15, 1, 0, "fill_s15");
    rd(3'h7, 5'd31, 1, 0, "fill_s31");
    rd(3'h7, 5'd31, 0, 0, "hit_s31");
    exp_q.push_back('{K_FSTART, 0, 0, 0, "flush_start"});
    exp_q.push_back('{K_FEND, 0, 0, 32, "flush_end"});
    flush = 1'b1;
    step();
    flush = 1'b0;
    tag = 3'h4; index = 5'd15;
    mem_read = 1'b1;
    repeat (5) step();
    mem_read = 1'b0;
    repeat (30) step();
    rd(3'h3, 5'd0, 1, 0, "post_flush_s0");
    rd(3'h4, 5'd15, 1, 0, "post_flush_s15");
    rd(3'h7, 5'd31, 1, 0, "post_flush_s31");

    // Asynchronous reset in the middle of a refill
    tag = 3'h2; index = 5'd9;
    exp_q.push_back('{K_RMISS, 0, 0, 0, "miss_before_rst"});
    mem_read = 1'b1;
    step();
    mem_read = 1'b0;
    step();
    #2 rst = 1'b0;
    #1;
    check("async_rst_stall", int'(stall), 0);
    check("async_rst_read_refill", int'({read, refill}), 0);
    step();
    rst = 1'b1;
    step();
    rd(3'h1, 5'd7, 1, 0, "rst_lost_line");
    rd(3'h2, 5'd9, 1, 0, "rst_no_partial");

    // 4-way build: five tags into set 1
    rd4(3'h1, 2'd1, 1, 0, "w4_t1");
    rd4(3'h2, 2'd1, 1, 1, "w4_t2");
    rd4(3'h3, 2'd1, 1, 2, "w4_t3");
    rd4(3'h4, 2'd1, 1, 3, "w4_t4");
    rd4(3'h3, 2'd1, 0, 2, "w4_hit_t3");
    rd4(3'h4, 2'd1, 0, 3, "w4_hit_t4");
    rd4(3'h5, 2'd1, 1, 0, "w4_t5_rr");
    rd4(3'h5, 2'd1, 0, 0, "w4_hit_t5");
    rd4(3'h2, 2'd1, 0, 1, "w4_hit_t2");

    repeat (3) step();
    check("exp_q_drained", exp_q.size(), 0);
    check("exp4_q_drained", exp4_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
